note_recorder: RTL and testbench

NOTE_RECORDER -- requirements
Module: note_recorder

---
 rtl/note_recorder.sv | 219 +++++++++++++++++++++
 tb/tb_note_recorder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/note_recorder.sv
// ----------------------------------------------------------------------------
// note_recorder
//
// Records a played melody as a list of {note, pitch, duration} entries for the
// note-memory player. Raw piano keys and pitch selector are debounced, then a
// five-state recorder (IDLE, ARMED, HOLD, GAP, DONE) measures how long each
// note and each rest lasts in ticks of TICK_CYCLES clocks. It emits one write
// strobe per finished entry.
//
// Ports
//   clk      in   system clock, rising edge
//   rst_n    in   asynchronous active-low reset
//   rec_en   in   level, high while a recording session is active
//   keys     in   [6:0] raw keys, bit i = note i (valid only when one-hot)
//   pitch    in   [2:0] octave/pitch selector, debounced together with keys
//   wr_en    out  one-cycle write strobe
//   wr_addr  out  [7:0] entry index being written
//   wr_data  out  [9:0] {note[6:0], pitch[2:0]}; note 0 = rest
//   wr_dur   out  [7:0] entry duration in ticks (1..255)
//   length   out  [7:0] entries written in this session
//   full     out  length has reached DEPTH
//   busy     out  recorder is in ARMED, HOLD or GAP
// ----------------------------------------------------------------------------
module note_recorder #(
    parameter int TICK_CYCLES     = 10000000,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DEPTH           = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rec_en,
    input  logic [6:0] keys,
    input  logic [2:0] pitch,
    output logic       wr_en,
    output logic [7:0] wr_addr,
    output logic [9:0] wr_data,
    output logic [7:0] wr_dur,
    output logic [7:0] length,
    output logic       full,
    output logic       busy
);

    localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int TK_W = $clog2(TICK_CYCLES + 1);
    localparam logic [DB_W-1:0] DB_MAX   = DB_W'(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_ONE   = DB_W'(1);
    localparam logic [TK_W-1:0] TK_MAX   = TK_W'(TICK_CYCLES - 1);
    localparam logic [TK_W-1:0] TK_ONE   = TK_W'(1);
    localparam logic [7:0]      LEN_LAST = 8'(DEPTH - 1);

    typedef enum logic [2:0] {IDLE, ARMED, HOLD, GAP, DONE} state_t;

    // Duration counter saturates at 255 ticks.
    function automatic logic [7:0] dur_add(input logic [7:0] d, input logic inc);
        if (inc && (d != 8'hFF)) return d + 8'd1;
        return d;
    endfunction

    // Every written entry lasts at least one tick.
    function automatic logic [7:0] dur_min1(input logic [7:0] d);
        return (d == 8'd0) ? 8'd1 : d;
    endfunction

    // ---------------- debounce stage ----------------
    logic [9:0]      smp;
    logic [DB_W-1:0] db_cnt;
    logic [DB_W-1:0] db_cnt_nxt;
    logic [6:0]      key_db;
    logic [2:0]      pitch_db;

    // db_cnt_nxt = number of consecutive identical samples including this one.
    always_comb begin
        db_cnt_nxt = DB_ONE;
        if ({keys, pitch} == smp)
            db_cnt_nxt = (db_cnt >= DB_MAX) ? db_cnt : db_cnt + DB_ONE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            smp      <= '0;
            db_cnt   <= '0;
            key_db   <= '0;
            pitch_db <= '0;
        end else begin
            smp    <= {keys, pitch};
            db_cnt <= db_cnt_nxt;
            if (db_cnt_nxt >= DB_MAX)
                {key_db, pitch_db} <= {keys, pitch};
        end
    end

    // ---------------- recorder stage ----------------
    state_t          state;
    logic            rec_en_q;
    logic [9:0]      held;
    logic [TK_W-1:0] tick_cnt;
    logic [7:0]      dur;

    logic            tick_done;
    logic [7:0]      dur_nxt;
    logic [9:0]      cur_nk;
    logic            key_valid;
    logic            key_chg;
    logic            last_slot;

    // dur_nxt already includes a tick completing this cycle, so an entry that
    // ends on a tick boundary gets credit for that tick.
    always_comb begin
        tick_done = (tick_cnt == TK_MAX);
        dur_nxt   = dur_add(dur, tick_done);
        cur_nk    = {key_db, pitch_db};
        key_valid = $onehot(key_db);
        key_chg   = (cur_nk != held);
        last_slot = (length == LEN_LAST);
    end

    // rec_en_q resets high so a rec_en already high at reset release is not
    // taken as a rising edge; a session needs a fresh low-to-high transition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rec_en_q <= 1'b1;
            held     <= '0;
            tick_cnt <= '0;
            dur      <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
            wr_dur   <= '0;
            length   <= '0;
            full     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            wr_en    <= 1'b0;
            rec_en_q <= rec_en;
            case (state)
                IDLE: begin
                    if (rec_en && !rec_en_q) begin
                        state    <= ARMED;
                        busy     <= 1'b1;
                        length   <= '0;
                        wr_addr  <= '0;
                        full     <= 1'b0;
                        tick_cnt <= '0;
                        dur      <= '0;
                    end
                end
                ARMED: begin
                    if (!rec_en) begin
                        state <= DONE;
                        busy  <= 1'b0;
                    end else if (key_valid) begin
                        state    <= HOLD;
                        held     <= cur_nk;
                        tick_cnt <= '0;
                        dur      <= '0;
                    end
                end
                HOLD: begin
                    tick_cnt <= tick_done ? '0 : tick_cnt + TK_ONE;
                    dur      <= dur_nxt;
                    // A key change and a rec_en drop both close the held note.
                    if (key_chg || !rec_en) begin
                        wr_en    <= 1'b1;
                        wr_addr  <= length;
                        wr_data  <= held;
                        wr_dur   <= dur_min1(dur_nxt);
                        length   <= length + 8'd1;
                        tick_cnt <= '0;
                        dur      <= '0;
                        if (last_slot)
                            full <= 1'b1;
                        if (last_slot || !rec_en) begin
                            state <= DONE;
                            busy  <= 1'b0;
                        end else if (key_valid) begin
                            held <= cur_nk;
                        end else begin
                            state <= GAP;
                        end
                    end
                end
                GAP: begin
                    tick_cnt <= tick_done ? '0 : tick_cnt + TK_ONE;
                    dur      <= dur_nxt;
                    if (!rec_en) begin
                        // trailing rest is discarded
                        state <= DONE;
                        busy  <= 1'b0;
                    end else if (key_valid) begin
                        tick_cnt <= '0;
                        dur      <= '0;
                        if (dur_nxt != 8'd0) begin
                            wr_en   <= 1'b1;
                            wr_addr <= length;
                            wr_data <= '0;
                            wr_dur  <= dur_nxt;
                            length  <= length + 8'd1;
                        end
                        if ((dur_nxt != 8'd0) && last_slot) begin
                            full  <= 1'b1;
                            state <= DONE;
                            busy  <= 1'b0;
                        end else begin
                            state <= HOLD;
                            held  <= cur_nk;
                        end
                    end
                end
                DONE: begin
                    if (!rec_en)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_note_recorder.sv
// ----------------------------------------------------------------------------
// tb_note_recorder
//
// Directed bench for note_recorder with TICK_CYCLES = 4, DEBOUNCE_CYCLES = 2,
// DEPTH = 32. A negedge monitor logs every write strobe; each scenario then
// compares the logged entries and status outputs against hand-derived values.
// ----------------------------------------------------------------------------
module tb_note_recorder;

    logic       clk;
    logic       rst_n;
    logic       rec_en;
    logic [6:0] keys;
    logic [2:0] pitch;
    logic       wr_en;
    logic [7:0] wr_addr;
    logic [9:0] wr_data;
    logic [7:0] wr_dur;
    logic [7:0] length;
    logic       full;
    logic       busy;

    note_recorder #(
        .TICK_CYCLES     (4),
        .DEBOUNCE_CYCLES (2),
        .DEPTH           (32)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .rec_en  (rec_en),
        .keys    (keys),
        .pitch   (pitch),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .wr_dur  (wr_dur),
        .length  (length),
        .full    (full),
        .busy    (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // write log, filled only by the monitor
    int log_addr [128];
    int log_data [128];
    int log_dur  [128];
    int nwr = 0;

    always @(negedge clk) begin
        if (wr_en && nwr < 128) begin
            log_addr[nwr] = int'(wr_addr);
            log_data[nwr] = int'(wr_data);
            log_dur[nwr]  = int'(wr_dur);
            nwr = nwr + 1;
        end
    end

    int checks   = 0;
    int failures = 0;
    int base;

    task automatic check(input string tag, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_en"},   int'(wr_en),   0);
        check({tag, "_wr_addr"}, int'(wr_addr), 0);
        check({tag, "_wr_data"}, int'(wr_data), 0);
        check({tag, "_wr_dur"},  int'(wr_dur),  0);
        check({tag, "_length"},  int'(length),  0);
        check({tag, "_full"},    int'(full),    0);
        check({tag, "_busy"},    int'(busy),    0);
    endtask

    // settle to IDLE with no key, then raise rec_en and wait in ARMED
    task automatic start_session();
        keys   = 7'd0;
        pitch  = 3'd0;
        rec_en = 1'b0;
        step(4);
        rec_en = 1'b1;
        step(3);
        base = nwr;
    endtask

    // {note, pitch} packing helper for expected wr_data
    function automatic int nk(input int note, input int p);
        return (note << 3) | p;
    endfunction

    initial begin
        rst_n  = 1'b0;
        rec_en = 1'b0;
        keys   = 7'd0;
        pitch  = 3'd0;
        step(2);
        check_reset_outputs("rst");
        rst_n = 1'b1;
        step(2);

        // single note held 12 cycles -> one entry of 3 ticks
        start_session();
        keys = 7'b0000001; pitch = 3'd2;
        step(12);
        keys = 7'd0;
        step(6);
        check("t1_nwr",   nwr - base, 1);
        check("t1_addr",  log_addr[base], 0);
        check("t1_data",  log_data[base], 10'b0000001_010);
        check("t1_dur",   log_dur[base], 3);
        check("t1_len",   int'(length), 1);
        check("t1_busy",  int'(busy), 1);
        rec_en = 1'b0;
        step(3);
        check("t1_nwr_end", nwr - base, 1);
        check("t1_len_end", int'(length), 1);
        check("t1_busy_end", int'(busy), 0);

        // note A, rest, note B flushed by rec_en falling
        start_session();
        keys = 7'b0000100; pitch = 3'd1;
        step(8);
        keys = 7'd0; pitch = 3'd0;
        step(8);
        keys = 7'b0010000; pitch = 3'd5;
        step(8);
        rec_en = 1'b0;
        step(1);
        check("t2_busy_done", int'(busy), 0);
        step(2);
        check("t2_nwr",   nwr - base, 3);
        check("t2_addr0", log_addr[base],     0);
        check("t2_data0", log_data[base],     nk(4, 1));
        check("t2_dur0",  log_dur[base],      2);
        check("t2_addr1", log_addr[base + 1], 1);
        check("t2_data1", log_data[base + 1], 0);
        check("t2_dur1",  log_dur[base + 1],  2);
        check("t2_addr2", log_addr[base + 2], 2);
        check("t2_data2", log_data[base + 2], nk(16, 5));
        check("t2_dur2",  log_dur[base + 2],  1);
        check("t2_len",   int'(length), 3);

        // two keys at once is never a valid note
        start_session();
        keys = 7'b0000011;
        step(20);
        rec_en = 1'b0;
        step(3);
        check("t3_nwr", nwr - base, 0);
        check("t3_len", int'(length), 0);

        // 33 alternating notes fill 32 slots
        start_session();
        for (int i = 0; i < 33; i++) begin
            keys  = (i % 2 == 1) ? 7'b0000010 : 7'b0000001;
            pitch = 3'(i % 8);
            step(6);
        end
        keys = 7'd0;
        step(6);
        check("t4_full_sess", int'(full), 1);
        rec_en = 1'b0;
        step(3);
        check("t4_nwr",  nwr - base, 32);
        check("t4_len",  int'(length), 32);
        check("t4_full", int'(full), 1);
        for (int i = 0; i < 32; i++) begin
            check($sformatf("t4_addr%0d", i), log_addr[base + i], i);
            check($sformatf("t4_data%0d", i), log_data[base + i],
                  nk((i % 2 == 1) ? 2 : 1, i % 8));
        end

        // per-cycle bouncing produces nothing; the stable key is recorded
        start_session();
        for (int i = 0; i < 10; i++) begin
            keys = (i % 2 == 1) ? 7'b0000001 : 7'b0000010;
            step(1);
        end
        keys = 7'b1000000; pitch = 3'd3;
        step(12);
        keys = 7'd0; pitch = 3'd0;
        step(6);
        rec_en = 1'b0;
        step(3);
        check("t5_nwr",  nwr - base, 1);
        check("t5_data", log_data[base], nk(64, 3));
        check("t5_dur",  log_dur[base], 3);
        check("t5_len",  int'(length), 1);

        // asynchronous reset while holding a note
        start_session();
        keys = 7'b0000001; pitch = 3'd0;
        step(8);
        check("t6_busy_pre", int'(busy), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        step(1);
        rst_n = 1'b1;
        keys = 7'd0;
        step(6);
        keys = 7'b0000010;
        step(6);
        keys = 7'd0;
        step(6);
        check("t6_nwr_after", nwr - base, 0);
        check("t6_busy_after", int'(busy), 0);
        check("t6_len_after", int'(length), 0);

        // a fresh rising edge starts a new session normally
        start_session();
        keys = 7'b0000100; pitch = 3'd1;
        step(12);
        keys = 7'd0; pitch = 3'd0;
        step(6);
        check("t6_nwr_new",  nwr - base, 1);
        check("t6_data_new", log_data[base], nk(4, 1));
        check("t6_dur_new",  log_dur[base], 3);
        rec_en = 1'b0;
        step(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
